sq_sum_pipeline: RTL and testbench
==================================

Name: sq_sum_pipeline

Overview:
Parametrised successor of the fixed 9-bit dual squaring stage. Accepts NCH signed differences per transaction, squares each over a configurable number of register stages, then sums the squares into one squared distance. Adds a valid/ready handshake with backpressure and a completed-transaction counter. Sits between the subtraction stage and the distance compare/accumulate stage.

Parameters:
IN_W, 9, width of each signed difference input
NCH, 2, number of channels (1..8)
STAGES, 2, register stages in the squaring section (1..4)
OUT_W, 2*IN_W+$clog2(NCH) (NCH=1 -> 2*IN_W), width of summed result
CNT_W, 16, width of completed-transaction counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_data  in  NCH*IN_W  channel i signed difference at bits [i*IN_W +: IN_W]
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output this cycle
out_sq  out  NCH*2*IN_W  channel i unsigned square at [i*2*IN_W +: 2*IN_W]
out_sum  out  OUT_W  unsigned sum of all channel squares
out_cnt  out  CNT_W  count of output handshakes completed

Behaviour:
- Reset (rst=1, any time, asynchronous): all stage valid bits, data registers, out_sq, out_sum, out_cnt cleared to 0; out_valid=0; in_ready=0 while rst is high. In-flight transactions are discarded.
- Global advance: en = out_ready | ~out_valid. in_ready = en & ~rst. All pipeline registers (data and valid) load only when en=1; otherwise everything holds.
- Accept: input transfer when in_valid & in_ready. Stage-0 valid loads in_valid & en.
- Latency: STAGES+1 cycles from accept to out_valid, with no stall. Squares computed in stage 1; stages 2..STAGES delay; final stage registers the sum.
- Throughput: one transaction per cycle while out_ready=1.
- Arithmetic: square of sign-extended input, result non-negative, held in 2*IN_W bits unsigned. Most-negative input (-2^(IN_W-1)) squares to 2^(2*IN_W-2) without overflow. Sum zero-extends each square to OUT_W. No overflow possible at the default OUT_W.
- out_sq is registered alongside out_sum in the final stage, so both belong to the same transaction.
- Stall: while out_valid=1 and out_ready=0, out_sq, out_sum and out_valid stay stable and in_ready=0.
- Bubbles: when out_valid=0, en=1 and bubbles advance/collapse naturally. No combinational path from in_valid to out_valid.
- out_cnt: increments by 1 on each out_valid & out_ready. Wraps from 2^CNT_W-1 to 0.
- Simultaneous output handshake and input accept in the same cycle is legal. Both take effect.

Optional Feature:
SQ_THRESH_EN:
- Defined: adds input thresh (OUT_W, unsigned, sampled at accept and carried through the pipeline with its transaction) and output out_hit (1). out_hit=1 when out_sum < carried thresh. out_hit is registered in the final stage, reset 0, and holds during stall.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 transactions in flight -> out_valid=0, out_sum=0, out_cnt=0, in_ready=0. After release, in_ready=1, and neither transaction ever emerges.
- Basic, defaults, out_ready=1: in_data ch0=3, ch1=-4 -> exactly 3 cycles later out_valid=1, out_sq ch0=9, ch1=16, out_sum=25.
- Extremes: ch0=-256, ch1=-256 -> out_sq 65536 each, out_sum=131072. ch0=255, ch1=0 -> out_sum=65025.
- Backpressure: stream 5 back-to-back transactions, hold out_ready=0 for 4 cycles after the first output -> output holds first result stable and in_ready=0. On release, all 5 results emerge in order with no loss or duplicate. out_cnt=5.
- Parameter sweep: IN_W=4, NCH=4, STAGES=1, inputs -8,7,-1,0 -> latency 2, out_sum=114 (OUT_W=10). Also run STAGES=4 -> latency 5.
- SQ_THRESH_EN defined: thresh=26 with out_sum=25 -> out_hit=1. thresh=25 -> out_hit=0. CNT_W=2 with 5 handshakes -> out_cnt=1.

Source files
------------

// File: rtl/sq_sum_pipeline.sv
// sq_sum_pipeline: NCH-channel signed square-and-sum pipeline with valid/ready backpressure
// and a completed-transaction counter. Define SQ_THRESH_EN to add the thresh/out_hit compare.

module sq_sum_pipeline #(
    parameter int IN_W   = 9,
    parameter int NCH    = 2,
    parameter int STAGES = 2,
    parameter int OUT_W  = (NCH == 1) ? 2 * IN_W : 2 * IN_W + $clog2(NCH),
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*IN_W-1:0]    in_data,
`ifdef SQ_THRESH_EN
    input  logic [OUT_W-1:0]       thresh,
    output logic                   out_hit,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*2*IN_W-1:0]  out_sq,
    output logic [OUT_W-1:0]       out_sum,
    output logic [CNT_W-1:0]       out_cnt
);

    localparam int SQ_W  = 2 * IN_W;
    localparam int ALL_W = NCH * SQ_W;

    // Sign-extend before multiplying so the most-negative input squares without overflow.
    function automatic logic [SQ_W-1:0] square(input logic [IN_W-1:0] x);
        logic signed [SQ_W-1:0] xe;
        xe = {{IN_W{x[IN_W-1]}}, x};
        square = xe * xe;
    endfunction

    logic               en_s;
    logic [NCH*IN_W-1:0] in_r;
    logic               v0_r;
    logic [ALL_W-1:0]   sq_s;
    logic [ALL_W-1:0]   sq_r [STAGES];
    logic [STAGES-1:0]  v_r;
    logic [OUT_W-1:0]   sum_s;

    assign en_s     = out_ready | ~out_valid;
    assign in_ready = en_s & ~rst;

    // Stage 0: capture the accepted transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r <= '0;
            v0_r <= 1'b0;
        end else if (en_s) begin
            in_r <= in_data;
            v0_r <= in_valid;
        end
    end

    // Per-channel squares of the stage-0 data.
    always_comb begin
        sq_s = '0;
        for (int i = 0; i < NCH; i++) begin
            sq_s[i*SQ_W +: SQ_W] = square(in_r[i*IN_W +: IN_W]);
        end
    end

    // Stage 1 registers the squares; later stages only delay them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                sq_r[k] <= '0;
            end
            v_r <= '0;
        end else if (en_s) begin
            sq_r[0] <= sq_s;
            v_r[0]  <= v0_r;
            for (int k = 1; k < STAGES; k++) begin
                sq_r[k] <= sq_r[k-1];
                v_r[k]  <= v_r[k-1];
            end
        end
    end

    // Zero-extended sum of the last delay stage's squares.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NCH; i++) begin
            sum_s = sum_s + OUT_W'(sq_r[STAGES-1][i*SQ_W +: SQ_W]);
        end
    end

    // Final stage: out_sq and out_sum register together so they share a transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sq    <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (en_s) begin
            out_sq    <= sq_r[STAGES-1];
            out_sum   <= sum_s;
            out_valid <= v_r[STAGES-1];
        end
    end

    // Completed output handshakes, wrapping at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (out_valid & out_ready) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

`ifdef SQ_THRESH_EN
    logic [OUT_W-1:0] th0_r;
    logic [OUT_W-1:0] th_r [STAGES];

    // Threshold travels alongside its transaction and is compared in the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th0_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                th_r[k] <= '0;
            end
            out_hit <= 1'b0;
        end else if (en_s) begin
            th0_r   <= thresh;
            th_r[0] <= th0_r;
            for (int k = 1; k < STAGES; k++) begin
                th_r[k] <= th_r[k-1];
            end
            out_hit <= (sum_s < th_r[STAGES-1]);
        end
    end
`endif

endmodule

// File: tb/tb_sq_sum_pipeline.sv
// Scoreboard bench for sq_sum_pipeline: randomized and directed stimulus against an arithmetic
// reference model, plus small parameter-sweep instances for latency and counter wrap.

module tb_sq_sum_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_sq;
    logic [18:0] out_sum;
    logic [15:0] out_cnt;
    logic [18:0] thresh;
`ifdef SQ_THRESH_EN
    logic        out_hit;
    logic        out_hit_b;
    logic        out_hit_c;
`endif

    logic        in_valid_b, in_ready_b, out_valid_b;
    logic [15:0] in_data_b;
    logic [31:0] out_sq_b;
    logic [9:0]  out_sum_b;
    logic [1:0]  out_cnt_b;
    logic        in_valid_c, in_ready_c, out_valid_c;
    logic [31:0] out_sq_c;
    logic [9:0]  out_sum_c;
    logic [15:0] out_cnt_c;

    always #5 clk = ~clk;

    sq_sum_pipeline dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SQ_THRESH_EN
        .thresh(thresh), .out_hit(out_hit),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sq(out_sq), .out_sum(out_sum),
        .out_cnt(out_cnt)
    );

    sq_sum_pipeline #(.IN_W(4), .NCH(4), .STAGES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
`ifdef SQ_THRESH_EN
        .thresh(10'd0), .out_hit(out_hit_b),
`endif
        .out_valid(out_valid_b), .out_ready(1'b1), .out_sq(out_sq_b), .out_sum(out_sum_b),
        .out_cnt(out_cnt_b)
    );

    sq_sum_pipeline #(.IN_W(4), .NCH(4), .STAGES(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_b),
`ifdef SQ_THRESH_EN
        .thresh(10'd0), .out_hit(out_hit_c),
`endif
        .out_valid(out_valid_c), .out_ready(1'b1), .out_sq(out_sq_c), .out_sum(out_sum_c),
        .out_cnt(out_cnt_c)
    );

    typedef struct {
        logic [35:0] sq;
        logic [18:0] sum;
        logic        hit;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cnt_model = 0;
    int   stall_seen = 0;
    int   mode = 0;
    int   stall_left = 0;
    bit   stall_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] pk(input int a, input int b);
        logic [8:0] la;
        logic [8:0] lb;
        la = 9'(a);
        lb = 9'(b);
        return {lb, la};
    endfunction

    // Reference: plain integer squares of each signed channel and their sum.
    function automatic exp_t model(input logic [17:0] d, input logic [18:0] thr);
        exp_t e;
        int   v;
        int   s;
        s = 0;
        e.sq = '0;
        for (int ch = 0; ch < 2; ch++) begin
            v = int'($signed(d[ch*9 +: 9]));
            e.sq[ch*18 +: 18] = 18'(v * v);
            s += v * v;
        end
        e.sum = 19'(s);
        e.hit = (s < int'(thr));
        return e;
    endfunction

    // out_ready policy: 0 always ready, 1 random, 2 stall four cycles on the first output.
    always @(negedge clk) begin
        case (mode)
            1: begin
                out_ready  = (($urandom() % 4) != 0);
                stall_done = 1'b0;
                stall_left = 0;
            end
            2: begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (out_valid && !stall_done) begin
                    out_ready  = 1'b0;
                    stall_left = 3;
                    stall_done = 1'b1;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: begin
                out_ready  = 1'b1;
                stall_done = 1'b0;
                stall_left = 0;
            end
        endcase
    end

    // Monitor: pop and compare on each output handshake; check stability during stalls.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            if (out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_sq", out_sq, e.sq);
                    chk("out_sum", out_sum, e.sum);
                    chk("out_cnt", out_cnt, 64'(16'(cnt_model)));
`ifdef SQ_THRESH_EN
                    chk("out_hit", out_hit, e.hit);
`endif
                    cnt_model++;
                end
            end else if (q.size() > 0) begin
                chk("stall_sum", out_sum, q[0].sum);
                chk("stall_sq", out_sq, q[0].sq);
                chk("stall_in_ready", in_ready, 1'b0);
                stall_seen++;
            end
        end
    end

    task automatic send(input logic [17:0] d, input logic [18:0] thr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        thresh   = thr;
        #1;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1'b1);
        end else begin
            q.push_back(model(d, thr));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 18'($urandom());
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        cnt_model = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 19'd0);
        chk("rst_out_cnt", out_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int   lat;
        int   lat_b;
        int   lat_c;
        int   nb;
        int   s0;
        logic [9:0]  sum_c;
        logic [31:0] sq_c;
        logic        ghost;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        thresh     = '0;
        in_valid_b = 1'b0;
        in_valid_c = 1'b0;
        in_data_b  = '0;
        mode       = 0;

        repeat (3) @(negedge clk);
        #3;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_out_sum", out_sum, 19'd0);
        chk("init_out_cnt", out_cnt, 16'd0);
        chk("init_in_ready", in_ready, 1'b0);
        rst = 1'b0;

        // Basic transaction and its latency.
        send(pk(3, -4), 19'd26);
        lat = -1;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        chk("basic_latency", 64'(lat), 64'd3);
        send(pk(3, -4), 19'd25);
        send(pk(-256, -256), 19'd0);
        send(pk(255, 0), 19'd65026);
        drain();

        // Reset with two transactions in flight: neither may emerge.
        send(pk(10, 20), 19'd0);
        send(pk(-30, 40), 19'd0);
        pulse_reset();
        ghost = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) ghost = 1'b1;
        end
        chk("no_ghost_after_rst", ghost, 1'b0);

        // Backpressure: five back-to-back, first output stalled four cycles.
        s0   = stall_seen;
        mode = 2;
        for (int i = 0; i < 5; i++) send(18'($urandom()), 19'($urandom()));
        drain();
        @(negedge clk);
        #3;
        chk("bp_out_cnt", out_cnt, 16'd5);
        chk("bp_stall_cycles", 64'(stall_seen - s0), 64'd4);
        mode = 0;

        // Parameter sweep: IN_W=4 NCH=4, STAGES=1 (5 txns, CNT_W=2) and STAGES=4.
        @(negedge clk);
        chk("b_in_ready", in_ready_b, 1'b1);
        chk("c_in_ready", in_ready_c, 1'b1);
        in_data_b  = 16'h0F78;
        in_valid_b = 1'b1;
        in_valid_c = 1'b1;
        lat_b = -1;
        lat_c = -1;
        nb    = 0;
        sum_c = '0;
        sq_c  = '0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            in_valid_c = 1'b0;
            if (k == 4) in_valid_b = 1'b0;
            if (out_valid_b) begin
                if (lat_b < 0) lat_b = k;
                nb++;
                chk("b_sum", out_sum_b, 10'd114);
                chk("b_sq", out_sq_b, 32'h0001_3140);
`ifdef SQ_THRESH_EN
                chk("b_hit", out_hit_b, 1'b0);
`endif
            end
            if (out_valid_c && lat_c < 0) begin
                lat_c = k;
                sum_c = out_sum_c;
                sq_c  = out_sq_c;
            end
        end
        chk("b_latency", 64'(lat_b), 64'd2);
        chk("b_count", 64'(nb), 64'd5);
        chk("b_cnt_wrap", out_cnt_b, 2'd1);
        chk("c_latency", 64'(lat_c), 64'd5);
        chk("c_sum", sum_c, 10'd114);
        chk("c_sq", sq_c, 32'h0001_3140);
        chk("c_cnt", out_cnt_c, 16'd1);

        // Randomized traffic with random backpressure.
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            if (($urandom() % 3) != 0) send(18'($urandom()), 19'($urandom_range(0, 140000)));
            else idle();
        end
        mode = 0;
        drain();
        @(negedge clk);
        #3;
        chk("final_out_cnt", out_cnt, 64'(16'(cnt_model)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
